// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the direct-mapped instruction cache:
//   - FSM state encoding (2 bits)
//   - default index width and the tag width derived from it
//   - address / instruction widths
//   - tag_width(): tag width for a non-default index width
// ---------------------------------------------------------------------------
package icache_pkg;

    localparam int ADDR_W          = 32;
    localparam int INS_W           = 32;
    localparam int INDEX_W_DEFAULT = 4;
    // Word-aligned lines: two byte-offset bits sit below the index.
    localparam int TAG_W           = ADDR_W - INDEX_W_DEFAULT - 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_EN  = 2'd1,
        ST_WAIT_MEM = 2'd2
    } state_t;

    function automatic int tag_width(input int index_w);
        return ADDR_W - index_w - 2;
    endfunction

endpackage

// File: rtl/icache_array.sv
// ---------------------------------------------------------------------------
// icache_array
// Storage for the direct-mapped cache: one valid bit, one tag and one data
// word per line. Lookup is combinational (hit + data for rd_index/rd_tag);
// the write port is registered and sets the line valid.
//
// Ports
//   clk, rst          clock, synchronous active-high reset (clears valid bits)
//   rd_index, rd_tag  lookup address fields
//   rd_hit            line valid and tag matches
//   rd_data           data word of the addressed line
//   wr_en             write the line at wr_index this edge
//   wr_index, wr_tag  fill address fields
//   wr_data           fill data word
// ---------------------------------------------------------------------------
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEFAULT,
    parameter int TAG_W_P = tag_width(INDEX_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [TAG_W_P-1:0] rd_tag,
    output logic               rd_hit,
    output logic [INS_W-1:0]   rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W_P-1:0] wr_tag,
    input  logic [INS_W-1:0]   wr_data
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] valid_reg;
    logic [LINES-1:0] wr_sel;
    logic [TAG_W_P-1:0] tag_mem  [LINES];
    logic [INS_W-1:0]   data_mem [LINES];

    // One-hot decode of the fill index.
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_index == INDEX_W'(gi));
        end
    endgenerate

    // Valid bits are the only state that needs clearing on reset; tag and
    // data contents are meaningless while their valid bit is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_reg | wr_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_data;
        end
    end

    assign rd_data = data_mem[rd_index];
    assign rd_hit  = valid_reg[rd_index] && (tag_mem[rd_index] == rd_tag);

endmodule

// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache
// Direct-mapped, one-word-per-line instruction cache between the fetch stage
// and the memory controller. Hits return in one cycle; misses issue a single
// mc_flag pulse once the controller is enabled and fill on mc_ins_rdy.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   rdy          global enable; low freezes the cache
//   if_req       fetch request (taken only while ic_ready)
//   if_addr      fetch PC (bits [1:0] ignored for lookup)
//   if_flush     pipeline flush, cancels any outstanding response
//   ic_ready     cache idle, may accept if_req
//   ins_valid    one-cycle pulse, ins_out valid
//   ins_out      fetched instruction (holds between pulses)
//   mc_enable    controller can take a request
//   mc_flag      one-cycle instruction-read request
//   mc_addr      request address, held from the miss onward
//   mc_ins       instruction returned by the controller
//   mc_ins_rdy   one-cycle pulse, mc_ins valid
// ---------------------------------------------------------------------------
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W = INDEX_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              ic_ready,
    output logic              ins_valid,
    output logic [INS_W-1:0]  ins_out,
    input  logic              mc_enable,
    output logic              mc_flag,
    output logic [ADDR_W-1:0] mc_addr,
    input  logic [INS_W-1:0]  mc_ins,
    input  logic              mc_ins_rdy
);

    localparam int TW = tag_width(INDEX_W);

    state_t             state_reg, state_next;
    logic               drop_reg, drop_next;
    logic [ADDR_W-1:0]  mc_addr_reg, mc_addr_next;
    logic               mc_flag_reg, mc_flag_next;
    logic               ins_valid_reg, ins_valid_next;
    logic [INS_W-1:0]   ins_out_reg, ins_out_next;
    logic               fill_req;

    logic               lookup_hit;
    logic [INS_W-1:0]   lookup_data;

    icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W_P (TW)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (if_addr[INDEX_W+1:2]),
        .rd_tag   (if_addr[ADDR_W-1:INDEX_W+2]),
        .rd_hit   (lookup_hit),
        .rd_data  (lookup_data),
        // A reset in the same cycle as mc_ins_rdy abandons the fill.
        .wr_en    (fill_req && rdy && !rst),
        .wr_index (mc_addr_reg[INDEX_W+1:2]),
        .wr_tag   (mc_addr_reg[ADDR_W-1:INDEX_W+2]),
        .wr_data  (mc_ins)
    );

    always_comb begin
        state_next     = state_reg;
        drop_next      = drop_reg;
        mc_addr_next   = mc_addr_reg;
        mc_flag_next   = 1'b0;
        ins_valid_next = 1'b0;
        ins_out_next   = ins_out_reg;
        fill_req       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // A flush in the same cycle discards the request entirely.
                if (if_req && !if_flush) begin
                    if (lookup_hit) begin
                        ins_valid_next = 1'b1;
                        ins_out_next   = lookup_data;
                    end else begin
                        mc_addr_next = if_addr;
                        state_next   = ST_WAIT_EN;
                    end
                end
            end

            ST_WAIT_EN: begin
                if (if_flush) begin
                    state_next = ST_IDLE;
                end else if (mc_enable) begin
                    mc_flag_next = 1'b1;
                    state_next   = ST_WAIT_MEM;
                end
            end

            ST_WAIT_MEM: begin
                // The request is already with the controller, so a flush can
                // only suppress the response; the line is still filled.
                if (mc_ins_rdy) begin
                    fill_req   = 1'b1;
                    drop_next  = 1'b0;
                    state_next = ST_IDLE;
                    if (!(drop_reg || if_flush)) begin
                        ins_valid_next = 1'b1;
                        ins_out_next   = mc_ins;
                    end
                end else if (if_flush) begin
                    drop_next = 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            drop_reg      <= 1'b0;
            mc_addr_reg   <= '0;
            mc_flag_reg   <= 1'b0;
            ins_valid_reg <= 1'b0;
            ins_out_reg   <= '0;
        end else if (rdy) begin
            state_reg     <= state_next;
            drop_reg      <= drop_next;
            mc_addr_reg   <= mc_addr_next;
            mc_flag_reg   <= mc_flag_next;
            ins_valid_reg <= ins_valid_next;
            ins_out_reg   <= ins_out_next;
        end else begin
            // Stall freezes everything except the two pulse outputs, which
            // must never stretch to a second cycle.
            mc_flag_reg   <= 1'b0;
            ins_valid_reg <= 1'b0;
        end
    end

    assign ic_ready  = (state_reg == ST_IDLE);
    assign ins_valid = ins_valid_reg;
    assign ins_out   = ins_out_reg;
    assign mc_flag   = mc_flag_reg;
    assign mc_addr   = mc_addr_reg;

endmodule

// File: tb/tb_icache.sv
// ---------------------------------------------------------------------------
// tb_icache
// Self-checking bench for icache (INDEX_W=4). A small reference cache model
// predicts hit/miss; expected instructions go into a scoreboard queue when
// the stimulus that should produce them is driven, and a negedge monitor
// pops and compares on every ins_valid pulse.
// ---------------------------------------------------------------------------
module tb_icache;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy, if_req, if_flush, mc_enable, mc_ins_rdy;
    logic [31:0] if_addr, mc_ins;
    logic        ic_ready, ins_valid, mc_flag;
    logic [31:0] ins_out, mc_addr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int          flag_cnt    = 0;
    logic        mc_flag_prev = 1'b0;

    bit          model_valid [16];
    logic [25:0] model_tag   [16];
    logic [31:0] model_data  [16];

    always #5 clk = ~clk;

    icache #(.INDEX_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .ic_ready   (ic_ready),
        .ins_valid  (ins_valid),
        .ins_out    (ins_out),
        .mc_enable  (mc_enable),
        .mc_flag    (mc_flag),
        .mc_addr    (mc_addr),
        .mc_ins     (mc_ins),
        .mc_ins_rdy (mc_ins_rdy)
    );

    // Scoreboard monitor: every ins_valid must match the oldest expectation;
    // every mc_flag is counted and must not follow another mc_flag.
    always @(negedge clk) begin
        if (ins_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ins_valid ins_out=%h required no pulse", ins_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (ins_out !== mon_exp) begin
                    failures++;
                    $display("FAIL ins_out_data got=%h expected=%h", ins_out, mon_exp);
                end
            end
        end
        if (mc_flag === 1'b1) begin
            flag_cnt++;
            checks++;
            if (mc_flag_prev === 1'b1) begin
                failures++;
                $display("FAIL mc_flag_consecutive got=1 expected=0");
            end
        end
        mc_flag_prev = mc_flag;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_valid[i] = 1'b0;
    endtask

    // One complete fetch transaction. flush_mode: 0 none, 1 flush while in
    // WAIT_MEM before the response, 2 flush on the same edge as mc_ins_rdy.
    task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] word,
                         input int en_delay, input int rdy_stall, input int flush_mode);
        int          idx;
        int          n;
        int          f0;
        logic [25:0] tg;
        bit          exp_hit;
        bit          exp_v;

        idx     = int'(addr[5:2]);
        tg      = addr[31:6];
        exp_hit = model_valid[idx] && (model_tag[idx] == tg);

        n = 0;
        while (ic_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (ic_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_timeout got=%b expected=1", name, ic_ready);
        end

        f0 = flag_cnt;
        if (exp_hit) exp_q.push_back(model_data[idx]);
        if_req  = 1'b1;
        if_addr = addr;
        tick();
        if_req  = 1'b0;

        checks++;
        if (ins_valid !== exp_hit) begin
            failures++;
            $display("FAIL %s_hit_pulse got=%b expected=%b", name, ins_valid, exp_hit);
        end

        if (exp_hit) begin
            tick();
            checks++;
            if (ic_ready !== 1'b1 || flag_cnt != f0 || ins_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s_hit_idle got=ready%b/flags%0d/valid%b expected=ready1/flags%0d/valid0",
                         name, ic_ready, flag_cnt - f0, ins_valid, 0);
            end
            $display("fetch %s addr=%h hit ins=%h", name, addr, model_data[idx]);
            return;
        end

        checks++;
        if (ic_ready !== 1'b0 || mc_addr !== addr) begin
            failures++;
            $display("FAIL %s_miss_latch got=ready%b/addr%h expected=ready0/addr%h",
                     name, ic_ready, mc_addr, addr);
        end

        mc_enable = 1'b0;
        for (int i = 0; i < en_delay; i++) begin
            tick();
            checks++;
            if (mc_flag !== 1'b0 || mc_addr !== addr) begin
                failures++;
                $display("FAIL %s_wait_en_hold got=flag%b/addr%h expected=flag0/addr%h",
                         name, mc_flag, mc_addr, addr);
            end
        end

        mc_enable = 1'b1;
        if (rdy_stall > 0) begin
            rdy = 1'b0;
            for (int i = 0; i < rdy_stall; i++) begin
                tick();
                checks++;
                if (mc_flag !== 1'b0 || ic_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_rdy_stall got=flag%b/ready%b expected=flag0/ready0",
                             name, mc_flag, ic_ready);
                end
            end
            rdy = 1'b1;
        end
        tick();
        mc_enable = 1'b0;
        checks++;
        if (mc_flag !== 1'b1 || mc_addr !== addr) begin
            failures++;
            $display("FAIL %s_mc_flag got=flag%b/addr%h expected=flag1/addr%h",
                     name, mc_flag, mc_addr, addr);
        end
        tick();
        checks++;
        if (mc_flag !== 1'b0) begin
            failures++;
            $display("FAIL %s_flag_width got=%b expected=0", name, mc_flag);
        end

        if (flush_mode == 1) begin
            if_flush = 1'b1;
            tick();
            if_flush = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (mc_addr !== addr || ic_ready !== 1'b0 || ins_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s_wait_mem_hold got=addr%h/ready%b/valid%b expected=addr%h/ready0/valid0",
                         name, mc_addr, ic_ready, ins_valid, addr);
            end
        end

        exp_v      = (flush_mode == 0);
        mc_ins     = word;
        mc_ins_rdy = 1'b1;
        if (flush_mode == 2) if_flush = 1'b1;
        if (exp_v) exp_q.push_back(word);
        tick();
        mc_ins_rdy = 1'b0;
        if_flush   = 1'b0;
        checks++;
        if (ins_valid !== exp_v || ic_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_response got=valid%b/ready%b expected=valid%b/ready1",
                     name, ins_valid, ic_ready, exp_v);
        end
        checks++;
        if (mc_addr !== addr || flag_cnt != f0 + 1) begin
            failures++;
            $display("FAIL %s_req_count got=addr%h/flags%0d expected=addr%h/flags1",
                     name, mc_addr, flag_cnt - f0, addr);
        end

        model_valid[idx] = 1'b1;
        model_tag[idx]   = tg;
        model_data[idx]  = word;

        tick();
        checks++;
        if (ins_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_pulse_width got=%b expected=0", name, ins_valid);
        end
        $display("fetch %s addr=%h miss fill=%h delivered=%b", name, addr, word, exp_v);
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b0; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
        mc_enable = 1'b0; mc_ins = '0; mc_ins_rdy = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0; rdy = 1'b1;
        model_clear();
        checks++;
        if (ic_ready !== 1'b1) begin failures++; $display("FAIL reset_ic_ready got=%b expected=1", ic_ready); end
        checks++;
        if (ins_valid !== 1'b0) begin failures++; $display("FAIL reset_ins_valid got=%b expected=0", ins_valid); end
        checks++;
        if (mc_flag !== 1'b0) begin failures++; $display("FAIL reset_mc_flag got=%b expected=0", mc_flag); end
        checks++;
        if (mc_addr !== 32'h0) begin failures++; $display("FAIL reset_mc_addr got=%h expected=0", mc_addr); end
        checks++;
        if (ins_out !== 32'h0) begin failures++; $display("FAIL reset_ins_out got=%h expected=0", ins_out); end
        $display("reset done");
    endtask

    task automatic test_cold_miss();
        fetch("cold_miss", 32'h0000_0010, 32'h00A0_0093, 0, 0, 0);
        checks++;
        if (ins_out !== 32'h00A0_0093) begin
            failures++;
            $display("FAIL cold_ins_out_hold got=%h expected=00a00093", ins_out);
        end
    endtask

    task automatic test_hit();
        fetch("hit", 32'h0000_0010, 32'h0, 0, 0, 0);
    endtask

    task automatic test_conflict();
        fetch("conflict", 32'h0000_0050, 32'h1234_5678, 0, 0, 0);
        fetch("conflict_back", 32'h0000_0010, 32'h00A0_0093, 0, 0, 0);
    endtask

    task automatic test_busy_controller();
        fetch("busy", 32'h0000_0104, 32'hDEAD_BEEF, 5, 0, 0);
    endtask

    task automatic test_flush_wait_mem();
        fetch("flush_mem", 32'h0000_0208, 32'h1111_2222, 1, 0, 1);
        fetch("flush_mem_hit", 32'h0000_0208, 32'h0, 0, 0, 0);
    endtask

    task automatic test_flush_same_edge();
        fetch("flush_edge", 32'h0000_030C, 32'h3333_4444, 0, 0, 2);
        fetch("flush_edge_hit", 32'h0000_030C, 32'h0, 0, 0, 0);
    endtask

    task automatic test_rdy_stall();
        fetch("rdy_stall", 32'h0000_040C, 32'h5555_6666, 0, 3, 0);
    endtask

    task automatic test_flush_wait_en();
        int f0;
        f0 = flag_cnt;
        if_req = 1'b1; if_addr = 32'h0000_0500; mc_enable = 1'b0;
        tick();
        if_req = 1'b0;
        checks++;
        if (ic_ready !== 1'b0) begin failures++; $display("FAIL flush_en_miss got=%b expected=0", ic_ready); end
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        checks++;
        if (ic_ready !== 1'b1) begin failures++; $display("FAIL flush_en_idle got=%b expected=1", ic_ready); end
        mc_enable = 1'b1;
        tick(); tick(); tick();
        mc_enable = 1'b0;
        checks++;
        if (flag_cnt != f0) begin
            failures++;
            $display("FAIL flush_en_no_flag got=%0d expected=0", flag_cnt - f0);
        end
        $display("flush in WAIT_EN addr=00000500 cancelled");
    endtask

    task automatic test_flush_idle();
        if_req = 1'b1; if_addr = 32'h0000_0010; if_flush = 1'b1;
        tick();
        checks++;
        if (ins_valid !== 1'b0 || ic_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle_hit got=valid%b/ready%b expected=valid0/ready1", ins_valid, ic_ready);
        end
        if_addr = 32'h0000_0600;
        tick();
        if_req = 1'b0; if_flush = 1'b0;
        checks++;
        if (ins_valid !== 1'b0 || ic_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle_miss got=valid%b/ready%b expected=valid0/ready1", ins_valid, ic_ready);
        end
        $display("flush in IDLE ignored requests");
    endtask

    task automatic test_stray_mc_ins_rdy();
        mc_ins = 32'hFFFF_0000; mc_ins_rdy = 1'b1;
        tick();
        mc_ins_rdy = 1'b0;
        checks++;
        if (ins_valid !== 1'b0 || ic_ready !== 1'b1) begin
            failures++;
            $display("FAIL stray_rdy got=valid%b/ready%b expected=valid0/ready1", ins_valid, ic_ready);
        end
        $display("stray mc_ins_rdy in IDLE ignored");
        fetch("stray_check", 32'h0000_040C, 32'h0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_fill();
        if_req = 1'b1; if_addr = 32'h0000_0700;
        tick();
        if_req = 1'b0; mc_enable = 1'b1;
        tick();
        mc_enable = 1'b0;
        tick();
        rst = 1'b1; mc_ins = 32'h7777_0000; mc_ins_rdy = 1'b1;
        tick();
        rst = 1'b0; mc_ins_rdy = 1'b0;
        model_clear();
        checks++;
        if (ic_ready !== 1'b1 || ins_valid !== 1'b0 || mc_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_fill got=ready%b/valid%b/addr%h expected=ready1/valid0/addr00000000",
                     ic_ready, ins_valid, mc_addr);
        end
        $display("reset during WAIT_MEM");
        fetch("after_reset", 32'h0000_0700, 32'h7777_8888, 0, 0, 0);
        fetch("after_reset_cold", 32'h0000_0010, 32'h00A0_0093, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_busy_controller();
        test_flush_wait_mem();
        test_flush_same_edge();
        test_rdy_stall();
        test_flush_wait_en();
        test_flush_idle();
        test_stray_mc_ins_rdy();
        test_reset_mid_fill();
        tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 clk  input  1  system clock, rising-edge.
REQ-002 rst  input  1  reset: synchronous, active-high.
REQ-003 rdy  input  1  global enable; low = every register holds.
REQ-004 if_req  input  1  fetch request, sampled only while ic_ready=1.
REQ-005 if_addr  input  32  fetch PC, word aligned, bits[1:0] ignored.
REQ-006 if_flush  input  1  pipeline flush; cancels any outstanding fetch response.
REQ-007 ic_ready  output  1  cache idle, can accept if_req this cycle.
REQ-008 ins_valid  output  1  one-cycle pulse, ins_out valid.
REQ-009 ins_out  output  32  fetched instruction.
REQ-010 mc_enable  input  1  memory controller can take an instruction request.
REQ-011 mc_flag  output  1  instruction-read request to memory controller.
REQ-012 mc_addr  output  32  instruction address to memory controller.
REQ-013 mc_ins  input  32  instruction word returned by the memory controller.
REQ-014 mc_ins_rdy  input  1  one-cycle pulse, mc_ins valid.
REQ-015 Parameter INDEX_W, default 4: direct-mapped, 2^INDEX_W lines of one 32-bit word each.

Function
REQ-016 Address split: index=addr[INDEX_W+1:2]; tag=addr[31:INDEX_W+2].
REQ-017 Each line holds one valid bit, one tag and one data word.
REQ-018 FSM states: IDLE, WAIT_EN, WAIT_MEM. ic_ready=1 only in IDLE.
REQ-019 IDLE, if_req and hit: ins_out=line data with ins_valid=1 on the next edge (1-cycle latency); FSM stays in IDLE.
REQ-020 IDLE, if_req and miss: latch if_addr into mc_addr and go to WAIT_EN; ins_valid stays 0.
REQ-021 WAIT_EN, mc_enable=1: drive mc_flag=1 for exactly one cycle and go to WAIT_MEM. mc_flag is never high two consecutive cycles.
REQ-022 WAIT_EN, mc_enable=0: hold the state with mc_flag=0.
REQ-023 mc_addr holds constant from the miss until the cycle after mc_ins_rdy, because the controller may sample it late, after finishing a data access.
REQ-024 WAIT_MEM, mc_ins_rdy=1: write the line (valid=1, tag, mc_ins), drive ins_out=mc_ins with ins_valid=1 next edge, then return to IDLE.
REQ-025 mc_ins_rdy outside WAIT_MEM is ignored.
REQ-026 if_flush in IDLE: no ins_valid next cycle, and a same-cycle if_req is ignored.
REQ-027 if_flush in WAIT_EN: return to IDLE with no mc_flag issued.
REQ-028 if_flush in WAIT_MEM: set a drop flag and stay in WAIT_MEM until mc_ins_rdy. The line is still filled, ins_valid is suppressed, then return to IDLE and clear the drop flag.
REQ-029 if_flush at the same edge as mc_ins_rdy: fill the line and suppress ins_valid.
REQ-030 ins_valid is a single-cycle pulse; ins_out holds its last value otherwise.
REQ-031 A fill and a same-index lookup never coincide, because lookups occur only in IDLE.

Reset
REQ-032 At reset: FSM=IDLE, all valid bits=0, drop flag=0, ins_valid=0, mc_flag=0, mc_addr=0, ins_out=0, ic_ready=1 from the cycle after reset.
REQ-033 rst has priority over rdy.
REQ-034 Reset while in WAIT_MEM abandons the fill; the controller is reset by the same rst.

Structure
REQ-035 Shared package holds: FSM state encoding (2 bits), INDEX_W default, derived TAG_W, instruction width constant 32.
REQ-036 One sub-module, icache_array, holds the storage: the valid/tag/data arrays, with a combinational hit lookup and a registered write port.
REQ-037 The FSM and handshake logic stay in icache.

Verification
REQ-038 Cold miss: rst, then if_req addr 0x00000010 with mc_enable=1. Required: one mc_flag with mc_addr=0x10. Then mc_ins_rdy with mc_ins=0x00A00093. Required: ins_valid with ins_out=0x00A00093 next cycle, ic_ready=1.
REQ-039 Hit: repeat fetch of 0x10. Required: ins_valid with 0x00A00093 one cycle later and no mc_flag.
REQ-040 Conflict: fetch 0x50 (same index, INDEX_W=4). Required: miss and refill. A later fetch of 0x10 misses again.
REQ-041 Busy controller: miss with mc_enable=0 for 5 cycles, then 1. Required: mc_flag exactly one cycle after enable rises, and mc_addr stable until mc_ins_rdy.
REQ-042 Flush in WAIT_MEM: pulse if_flush, then mc_ins_rdy. Required: no ins_valid, return to IDLE, and a following fetch of the same address hits.
REQ-043 rdy=0 for 3 cycles during WAIT_EN. Required: no state change and no mc_flag until rdy=1.
